// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per
// clock MSB-first, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating one quotient bit per cycle (N cycles)
// DONE  | results just loaded; done pulses for this one cycle
module seq_divider #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state, state_nxt;
  logic         accept;
  logic         last_iter;
  logic [N-1:0] dvd_q;
  logic [M-1:0] dvs_q;
  logic [M:0]   prem;
  logic [N-1:0] quo_acc;
  logic [CW-1:0] cnt;

  logic [M:0]   shifted;
  logic [M:0]   diff;
  logic         ge;
  logic [M:0]   prem_nxt;
  logic [N-1:0] quo_nxt;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // The restored remainder is always below the divisor, so the (M+1)-bit
  // shifted value can never overflow the compare.
  always_comb begin
    shifted  = (prem << 1) | (M+1)'(dvd_q[N-1]);
    diff     = shifted - {1'b0, dvs_q};
    ge       = (shifted >= {1'b0, dvs_q});
    prem_nxt = ge ? diff : shifted;
    quo_nxt  = (quo_acc << 1) | N'(ge);
  end

  assign last_iter = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; DONE accepts a new start like IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem        <= '0;
      quo_acc     <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= '0;
        div_by_zero <= 1'b1;
      end else begin
        dvd_q   <= dividend;
        dvs_q   <= divisor;
        prem    <= '0;
        quo_acc <= '0;
        cnt     <= '0;
      end
    end else if (state == CALC) begin
      dvd_q   <= dvd_q << 1;
      prem    <= prem_nxt;
      quo_acc <= quo_nxt;
      cnt     <= cnt + 1'b1;
      if (last_iter) begin
        quotient    <= quo_nxt;
        remainder   <= prem_nxt[M-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
